dkong_input_conditioner: RTL and testbench
==========================================

Name: dkong_input_conditioner

Overview:
- Sits directly upstream of dkong_system and drives its player, start and coin inputs: p1_*, p2_*, p1_sw, p2_sw and coin_sw.
- Synchronises the raw cabinet and board switch inputs into the masterclk domain, then debounces each one.
- Optionally neutralises opposing joystick directions.
- Converts each coin insertion into one fixed-width coin pulse with lockout.

Parameters:
- DEBOUNCE_CYCLES, 65536: consecutive cycles a synchronised input must hold a new value before the debounced value changes. Must be ≥ 2.
- COIN_PULSE_CYCLES, 3000000: width in cycles of coin_sw_out per accepted coin. Must be ≥ 1.
- SOCD_ENA, 1: 1 = opposing directions pressed together give neutral; 0 = pass-through.

Ports:
- masterclk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- p1_raw  in  5  player 1 raw inputs, active-high pressed; bits {b1,d,u,l,r} = [4:0].
- p2_raw  in  5  player 2 raw inputs, same bit order.
- p1_sw_raw  in  1  raw 1P start switch.
- p2_sw_raw  in  1  raw 2P start switch.
- coin_raw  in  1  raw coin switch.
- p1_r, p1_l, p1_u, p1_d, p1_b1  out  1 each  conditioned player 1 controls.
- p2_r, p2_l, p2_u, p2_d, p2_b1  out  1 each  conditioned player 2 controls.
- p1_sw, p2_sw  out  1 each  conditioned start switches.
- coin_sw  out  1  coin pulse.
- coin_total  out  8  count of accepted coins; wraps 255 -> 0.

Behaviour:
- Reset: all flops cleared, including synchroniser flops, debounced values, debounce counters and coin counter. Coin FSM goes to IDLE. Every output is 0 in the cycle after rst is sampled high. rst overrides any in-flight debounce or pulse.
- Synchroniser: two flops per raw bit (13 bits). Each raw bit gives s[i].
- Debounce, independent per bit:
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - When s[i] == db[i], the counter clears to 0.
  - When they differ and count == DEBOUNCE_CYCLES-1: db[i] <= s[i] and the counter clears.
  - When they differ otherwise, the counter increments.
  - A single-cycle glitch shorter than DEBOUNCE_CYCLES never changes db.
  - The counter cannot overflow.
- SOCD, when SOCD_ENA=1, per player:
  - db_l & db_r -> both l and r are 0.
  - db_u & db_d -> both u and d are 0.
  - b1 is unaffected.
- Output registers: all player and start outputs are registered from the SOCD result.
- Latency: a raw edge held stable reaches its output DEBOUNCE_CYCLES+3 edges later.
- Coin FSM, running on debounced coin dc:
  - IDLE: if dc==1, go to PULSE, load the pulse counter with COIN_PULSE_CYCLES-1, and increment coin_total.
  - PULSE: coin_sw=1. Decrement the counter each cycle. At 0, go to LOCKOUT.
  - LOCKOUT: coin_sw=0. Stay until dc==0, then go to IDLE.
  - coin_sw is high for exactly COIN_PULSE_CYCLES cycles, and its first high cycle is the cycle after IDLE->PULSE.
  - Releasing the coin during PULSE does not shorten the pulse. LOCKOUT then exits on the next cycle.
  - A coin held continuously gives exactly one pulse.
  - The earliest new pulse after a pulse ends is 2 cycles after LOCKOUT exit, which requires dc to rise again.
- Inputs held high through reset are treated as new presses after reset release: they debounce normally and, for coin, produce one pulse.
- All bits are processed in parallel. There is no interaction between bits other than SOCD.

Test Plan (DEBOUNCE_CYCLES=4, COIN_PULSE_CYCLES=10 unless stated):
- Debounce latency: reset, then raise p1_raw[0] and hold. p1_r must go 1 exactly 7 edges after the raw edge. Drop it and hold: p1_r must return to 0 after 7 edges.
- Glitch reject: pulse p2_raw[4] high for 3 cycles, then low. p2_b1 must stay 0. Pulse it for 6 cycles: p2_b1 must go high, then return low.
- SOCD: hold p1_raw l and r together, with SOCD_ENA=1. p1_l and p1_r must both stay 0, and a held p1_u still reaches 1. Repeat with SOCD_ENA=0: both go 1.
- Coin pulse: hold coin_raw for 50 cycles. coin_sw must be high for exactly 10 consecutive cycles, once, and coin_total goes 0->1. Release, then insert again: a second 10-cycle pulse follows and coin_total=2.
- Coin release mid-pulse: coin_raw high for 8 cycles. coin_sw must still be 10 cycles wide, and the FSM returns to IDLE.
- Reset mid-operation: assert rst during PULSE and partway through a debounce count. The next cycle all outputs are 0 and coin_total=0. With raw inputs held, the outputs re-assert after 7 edges from rst release.

Source files
------------

// File: rtl/dkong_input_conditioner.sv
// Input conditioning for dkong_system: two-flop synchronisers, per-bit debounce,
// optional opposing-direction (SOCD) neutralisation and a one-shot coin pulse with lockout.
module dkong_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 65536,
  parameter int unsigned COIN_PULSE_CYCLES = 3000000,
  parameter bit          SOCD_ENA          = 1'b1
) (
  input  logic       masterclk,
  input  logic       rst,
  input  logic [4:0] p1_raw,
  input  logic [4:0] p2_raw,
  input  logic       p1_sw_raw,
  input  logic       p2_sw_raw,
  input  logic       coin_raw,
  output logic       p1_r,
  output logic       p1_l,
  output logic       p1_u,
  output logic       p1_d,
  output logic       p1_b1,
  output logic       p2_r,
  output logic       p2_l,
  output logic       p2_u,
  output logic       p2_d,
  output logic       p2_b1,
  output logic       p1_sw,
  output logic       p2_sw,
  output logic       coin_sw,
  output logic [7:0] coin_total
);

  localparam int unsigned NumIn  = 13;
  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PulseW = (COIN_PULSE_CYCLES > 1) ? $clog2(COIN_PULSE_CYCLES) : 1;
  localparam logic [CntW-1:0]   DbMax   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PulseW-1:0] PulseLd = PulseW'(COIN_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPulse, StLockout} coin_state_e;

  // Bit map: [4:0] p1, [9:5] p2, [10] p1 start, [11] p2 start, [12] coin
  logic [NumIn-1:0] raw_vec;
  logic [NumIn-1:0] sync1_q, sync2_q;
  logic [NumIn-1:0] db_q;
  logic [CntW-1:0]  db_cnt_q [NumIn];
  logic [4:0]       p1_socd, p2_socd;
  logic [4:0]       p1_q, p2_q;
  logic [1:0]       sw_q;
  logic [PulseW-1:0] pulse_cnt_q;
  coin_state_e      coin_state_q;

  assign raw_vec = {coin_raw, p2_sw_raw, p1_sw_raw, p2_raw, p1_raw};

  // Neutralise left+right and up+down; b1 always passes through
  function automatic logic [4:0] socd(input logic [4:0] v);
    logic [4:0] o;
    o = v;
    if (SOCD_ENA) begin
      if (v[0] && v[1]) o[1:0] = 2'b00;
      if (v[2] && v[3]) o[3:2] = 2'b00;
    end
    return o;
  endfunction

  // Two-flop synchroniser into the masterclk domain
  always_ff @(posedge masterclk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_vec;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: a new value must persist for DEBOUNCE_CYCLES samples
  always_ff @(posedge masterclk) begin
    if (rst) begin
      db_q <= '0;
      for (int i = 0; i < NumIn; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumIn; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbMax) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    p1_socd = socd(db_q[4:0]);
    p2_socd = socd(db_q[9:5]);
  end

  // Registered player and start outputs
  always_ff @(posedge masterclk) begin
    if (rst) begin
      p1_q <= '0;
      p2_q <= '0;
      sw_q <= '0;
    end else begin
      p1_q <= p1_socd;
      p2_q <= p2_socd;
      sw_q <= db_q[11:10];
    end
  end

  assign {p1_b1, p1_d, p1_u, p1_l, p1_r} = p1_q;
  assign {p2_b1, p2_d, p2_u, p2_l, p2_r} = p2_q;
  assign {p2_sw, p1_sw}                  = sw_q;

  // Coin FSM: one fixed-width pulse per insertion, locked out until the coin releases
  always_ff @(posedge masterclk) begin
    if (rst) begin
      coin_state_q <= StIdle;
      pulse_cnt_q  <= '0;
      coin_sw      <= 1'b0;
      coin_total   <= '0;
    end else begin
      unique case (coin_state_q)
        StIdle: begin
          if (db_q[12]) begin
            coin_state_q <= StPulse;
            pulse_cnt_q  <= PulseLd;
            coin_sw      <= 1'b1;
            coin_total   <= coin_total + 8'd1;
          end
        end
        StPulse: begin
          if (pulse_cnt_q == '0) begin
            coin_state_q <= StLockout;
            coin_sw      <= 1'b0;
          end else begin
            pulse_cnt_q <= pulse_cnt_q - 1'b1;
          end
        end
        StLockout: begin
          if (!db_q[12]) coin_state_q <= StIdle;
        end
        default: begin
          coin_state_q <= StIdle;
          coin_sw      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dkong_input_conditioner.sv
// Directed bench for dkong_input_conditioner with DEBOUNCE_CYCLES=4, COIN_PULSE_CYCLES=10.
module tb_dkong_input_conditioner;

  logic       masterclk = 1'b0;
  logic       rst;
  logic [4:0] p1_raw, p2_raw;
  logic       p1_sw_raw, p2_sw_raw, coin_raw;

  logic p1_r, p1_l, p1_u, p1_d, p1_b1, p2_r, p2_l, p2_u, p2_d, p2_b1, p1_sw, p2_sw, coin_sw;
  logic [7:0] coin_total;
  logic ns_p1_r, ns_p1_l, ns_p1_u, ns_p1_d, ns_p1_b1, ns_p2_r, ns_p2_l, ns_p2_u, ns_p2_d;
  logic ns_p2_b1, ns_p1_sw, ns_p2_sw, ns_coin_sw;
  logic [7:0] ns_coin_total;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 masterclk = ~masterclk;

  dkong_input_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .COIN_PULSE_CYCLES(10),
    .SOCD_ENA         (1'b1)
  ) dut (
    .masterclk (masterclk), .rst(rst),
    .p1_raw    (p1_raw), .p2_raw(p2_raw),
    .p1_sw_raw (p1_sw_raw), .p2_sw_raw(p2_sw_raw), .coin_raw(coin_raw),
    .p1_r(p1_r), .p1_l(p1_l), .p1_u(p1_u), .p1_d(p1_d), .p1_b1(p1_b1),
    .p2_r(p2_r), .p2_l(p2_l), .p2_u(p2_u), .p2_d(p2_d), .p2_b1(p2_b1),
    .p1_sw(p1_sw), .p2_sw(p2_sw), .coin_sw(coin_sw), .coin_total(coin_total)
  );

  dkong_input_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .COIN_PULSE_CYCLES(10),
    .SOCD_ENA         (1'b0)
  ) dut_ns (
    .masterclk (masterclk), .rst(rst),
    .p1_raw    (p1_raw), .p2_raw(p2_raw),
    .p1_sw_raw (p1_sw_raw), .p2_sw_raw(p2_sw_raw), .coin_raw(coin_raw),
    .p1_r(ns_p1_r), .p1_l(ns_p1_l), .p1_u(ns_p1_u), .p1_d(ns_p1_d), .p1_b1(ns_p1_b1),
    .p2_r(ns_p2_r), .p2_l(ns_p2_l), .p2_u(ns_p2_u), .p2_d(ns_p2_d), .p2_b1(ns_p2_b1),
    .p1_sw(ns_p1_sw), .p2_sw(ns_p2_sw), .coin_sw(ns_coin_sw), .coin_total(ns_coin_total)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1ns past the last one
  task automatic step(input int n);
    repeat (n) @(posedge masterclk);
    #1;
  endtask

  function automatic logic [20:0] outs_main();
    return {coin_total, p1_r, p1_l, p1_u, p1_d, p1_b1, p2_r, p2_l, p2_u, p2_d, p2_b1,
            p1_sw, p2_sw, coin_sw};
  endfunction

  function automatic logic [20:0] outs_ns();
    return {ns_coin_total, ns_p1_r, ns_p1_l, ns_p1_u, ns_p1_d, ns_p1_b1, ns_p2_r, ns_p2_l,
            ns_p2_u, ns_p2_d, ns_p2_b1, ns_p1_sw, ns_p2_sw, ns_coin_sw};
  endfunction

  // Drive coin high for `hold` cycles over a `len`-cycle window; report pulse width and count
  task automatic coin_window(input int hold, input int len, output int width, output int pulses);
    logic prev;
    width  = 0;
    pulses = 0;
    prev   = coin_sw;
    for (int i = 0; i < len; i++) begin
      coin_raw = (i < hold);
      step(1);
      if (coin_sw) width++;
      if (coin_sw && !prev) pulses++;
      prev = coin_sw;
    end
    coin_raw = 1'b0;
  endtask

  initial begin
    int highs;
    int width;
    int pulses;

    rst = 1'b1; p1_raw = '0; p2_raw = '0; p1_sw_raw = 0; p2_sw_raw = 0; coin_raw = 0;
    step(2);
    check("reset_outs", {11'd0, outs_main()}, 32'd0);
    check("reset_outs_ns", {11'd0, outs_ns()}, 32'd0);
    rst = 1'b0;
    step(3);

    // Debounce latency, press then release
    p1_raw[0] = 1'b1;
    step(6);
    check("rise_edge6", {31'd0, p1_r}, 32'd0);
    step(1);
    check("rise_edge7", {31'd0, p1_r}, 32'd1);
    p1_raw[0] = 1'b0;
    step(6);
    check("fall_edge6", {31'd0, p1_r}, 32'd1);
    step(1);
    check("fall_edge7", {31'd0, p1_r}, 32'd0);

    // Glitch reject (3 cycles) and accept (6 cycles)
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      p2_raw[4] = (i < 3);
      step(1);
      if (p2_b1) highs++;
    end
    check("glitch3_b1", highs, 0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      p2_raw[4] = (i < 6);
      step(1);
      if (p2_b1) highs++;
    end
    check("pulse6_b1_width", highs, 6);
    check("pulse6_b1_final", {31'd0, p2_b1}, 32'd0);

    // SOCD: p1 l+r+u, p2 u+d+b1
    highs = 0;
    p1_raw = 5'b00111;
    p2_raw = 5'b11100;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (p1_l || p1_r || p2_u || p2_d) highs++;
    end
    check("socd_never_lr_ud", highs, 0);
    check("socd_p1", {27'd0, p1_b1, p1_d, p1_u, p1_l, p1_r}, 32'b00100);
    check("socd_p2", {27'd0, p2_b1, p2_d, p2_u, p2_l, p2_r}, 32'b10000);
    check("nosocd_p1", {27'd0, ns_p1_b1, ns_p1_d, ns_p1_u, ns_p1_l, ns_p1_r}, 32'b00111);
    check("nosocd_p2", {27'd0, ns_p2_b1, ns_p2_d, ns_p2_u, ns_p2_l, ns_p2_r}, 32'b11100);
    p1_raw = '0;
    p2_raw = '0;
    p1_sw_raw = 1'b1;
    step(12);
    check("clear_players", {22'd0, p1_r, p1_l, p1_u, p1_d, p1_b1, p2_r, p2_l, p2_u, p2_d, p2_b1},
          32'd0);
    check("p1_sw_on", {30'd0, p1_sw, p2_sw}, 32'b10);
    p1_sw_raw = 1'b0;
    step(12);

    // Coin held 50 cycles gives a single 10-cycle pulse
    coin_window(50, 65, width, pulses);
    check("coin1_width", width, 10);
    check("coin1_pulses", pulses, 1);
    check("coin1_total", {24'd0, coin_total}, 32'd1);
    coin_window(20, 40, width, pulses);
    check("coin2_width", width, 10);
    check("coin2_total", {24'd0, coin_total}, 32'd2);

    // Release mid-pulse keeps full width; FSM must be back in idle for the next coin
    coin_window(8, 40, width, pulses);
    check("coin3_width", width, 10);
    check("coin3_total", {24'd0, coin_total}, 32'd3);
    coin_window(8, 40, width, pulses);
    check("coin4_pulses", pulses, 1);
    check("coin4_total", {24'd0, coin_total}, 32'd4);

    // Reset mid-pulse and mid-debounce, with raw inputs held through and after reset
    coin_raw  = 1'b1;
    p1_raw[2] = 1'b1;
    step(4);
    p2_raw[0] = 1'b1;
    step(5);
    check("pre_rst_coin_sw", {31'd0, coin_sw}, 32'd1);
    check("pre_rst_p2_r", {31'd0, p2_r}, 32'd0);
    rst = 1'b1;
    step(1);
    check("rst_mid_outs", {11'd0, outs_main()}, 32'd0);
    rst = 1'b0;
    step(6);
    check("post_rst_edge6", {30'd0, p1_u, p2_r}, 32'd0);
    step(1);
    check("post_rst_edge7", {30'd0, p1_u, p2_r}, 32'b11);
    check("post_rst_coin", {23'd0, coin_sw, coin_total}, {23'd0, 1'b1, 8'd1});

    coin_raw = 1'b0;
    p1_raw   = '0;
    p2_raw   = '0;
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
